// File: rtl/spi_cmd_decoder.sv
// Command decoder behind a 12-bit SPI slave: executes one command per CS frame on a 4 x 8-bit register bank.
// Optional macro SPI_ECHO_EN: a NOP answers with the previous frame's command word instead of 12'h000.
module spi_cmd_decoder #(
  parameter int          SYNC_STAGES = 2,
  parameter int          ERR_W       = 8,
  parameter logic [7:0]  REG_RST     = 8'h00
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CS,
  input  logic [11:0]      data_in,
  output logic [11:0]      data_out,
  output logic [31:0]      regs_out,
  output logic             frame_valid,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    EXEC    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   cs_q;
  logic                   cs_s;
  logic                   cs_next;
  logic                   cs_rise;
  logic [7:0]             regs_q [4];

  logic [1:0]  op;
  logic [1:0]  addr;
  logic [7:0]  wdata;
  logic [11:0] resp;
  logic [11:0] nop_resp;
  logic        commit;
  logic        reg_we;
  logic        load_ok;
  logic        err_inc;

  // Synchronizer and edge detector idle high so reset release never looks like a frame end.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '1;
      cs_q   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], CS};
      cs_q   <= cs_s;
    end
  end

  assign cs_s    = sync_q[SYNC_STAGES-1];
  assign cs_next = sync_q[SYNC_STAGES-2];
  assign cs_rise = cs_s & ~cs_q;

`ifdef SPI_ECHO_EN
  logic [11:0] echo_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      echo_q <= 12'h000;
    end else if (commit) begin
      echo_q <= data_in;
    end
  end

  assign nop_resp = echo_q;
`else
  assign nop_resp = 12'h000;
`endif

  assign op    = data_in[11:10];
  assign addr  = data_in[9:8];
  assign wdata = data_in[7:0];

  // The word is stable in CAPTURE, so the op commits on the edge entering EXEC and its
  // results are visible together with the frame_valid pulse.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    reg_we  = 1'b0;
    resp    = 12'h000;
    case (op)
      2'b01: begin
        reg_we = 1'b1;
        resp   = {2'b01, addr, wdata};
      end
      2'b10:   resp = {2'b10, addr, regs_q[addr]};
      2'b11:   resp = 12'hFFF;
      default: resp = nop_resp;
    endcase
    case (state_q)
      IDLE:    if (cs_rise) state_d = CAPTURE;
      CAPTURE: begin
        commit  = 1'b1;
        state_d = EXEC;
      end
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Load only if synchronized CS is high before and after the commit edge, so data_out
  // can never move while the next frame is already shifting.
  assign load_ok = cs_s & cs_next;
  assign err_inc = commit & ((op == 2'b11) | ~load_ok);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      data_out  <= 12'h000;
      err_count <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= REG_RST;
    end else begin
      state_q <= state_d;
      if (commit && load_ok) data_out <= resp;
      if (commit && reg_we) regs_q[addr] <= wdata;
      if (err_inc && (err_count != {ERR_W{1'b1}})) err_count <= err_count + 1'b1;
    end
  end

  assign regs_out    = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};
  assign frame_valid = (state_q == EXEC);
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: table of full frames plus hand-written late-handoff,
// reset-abort and error-saturation sequences.
module tb_spi_cmd_decoder;

  logic        CLK;
  logic        RST;
  logic        CS;
  logic [11:0] data_in;
  logic [11:0] data_out;
  logic [31:0] regs_out;
  logic        frame_valid;
  logic [7:0]  err_count;
  logic [1:0]  fsm_state;

  int n_vec;
  int n_bad;

`ifdef SPI_ECHO_EN
  localparam logic [11:0] NOP_EXP = 12'h5A5;
`else
  localparam logic [11:0] NOP_EXP = 12'h000;
`endif

  typedef struct {
    logic [11:0] din;
    logic [11:0] exp_dout;
    logic [31:0] exp_regs;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t vecs [10];

  spi_cmd_decoder #(
    .SYNC_STAGES (2),
    .ERR_W       (8),
    .REG_RST     (8'h00)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .CS          (CS),
    .data_in     (data_in),
    .data_out    (data_out),
    .regs_out    (regs_out),
    .frame_valid (frame_valid),
    .err_count   (err_count),
    .fsm_state   (fsm_state)
  );

  // Clock and watchdog
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Ends the previous frame low, then raises CS with the word and watches 8 edges.
  // fv_pos = edge index after which frame_valid was seen (99 if more than once, -1 if never).
  task automatic run_frame(input logic [11:0] word, output int fv_pos);
    CS = 1'b0;
    repeat (3) tick();
    data_in = word;
    CS      = 1'b1;
    fv_pos  = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (frame_valid) fv_pos = (fv_pos == -1) ? k : 99;
    end
  endtask

  initial begin
    int fv_pos;
    int fv_seen;
    int moved;

    n_vec = 0;
    n_bad = 0;

    vecs[0] = '{12'h5A5, 12'h5A5, 32'h0000_A500, 8'd0};
    vecs[1] = '{12'h900, 12'h9A5, 32'h0000_A500, 8'd0};
    vecs[2] = '{12'hC12, 12'hFFF, 32'h0000_A500, 8'd1};
    vecs[3] = '{12'h7C3, 12'h7C3, 32'hC300_A500, 8'd1};
    vecs[4] = '{12'h642, 12'h642, 32'hC342_A500, 8'd1};
    vecs[5] = '{12'hB00, 12'hBC3, 32'hC342_A500, 8'd1};
    vecs[6] = '{12'h5A5, 12'h5A5, 32'hC342_A500, 8'd1};
    vecs[7] = '{12'h000, NOP_EXP, 32'hC342_A500, 8'd1};
    vecs[8] = '{12'h8FF, 12'h800, 32'hC342_A500, 8'd1};
    vecs[9] = '{12'h411, 12'h411, 32'hC342_A511, 8'd1};

    // Reset with CS idle
    RST     = 1'b1;
    CS      = 1'b1;
    data_in = 12'h000;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    fv_seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (frame_valid) fv_seen++;
    end
    check("reset_frame_valid", fv_seen, 0);
    check("reset_data_out", data_out, 12'h000);
    check("reset_regs", regs_out, 32'h0000_0000);
    check("reset_err", err_count, 8'd0);
    check("reset_state", fsm_state, 2'd0);

    // Table of complete frames
    for (int i = 0; i < 10; i++) begin
      run_frame(vecs[i].din, fv_pos);
      check($sformatf("v%0d_fv_edge", i), fv_pos, 4);
      check($sformatf("v%0d_data_out", i), data_out, vecs[i].exp_dout);
      check($sformatf("v%0d_regs", i), regs_out, vecs[i].exp_regs);
      check($sformatf("v%0d_err", i), err_count, vecs[i].exp_err);
    end

    // Late handoff: CS drops again 2 CLK after rising on a READ frame
    CS = 1'b0;
    repeat (3) tick();
    data_in = 12'hA00;
    CS      = 1'b1;
    tick();
    tick();
    CS      = 1'b0;
    moved   = 0;
    fv_pos  = -1;
    for (int k = 3; k <= 10; k++) begin
      tick();
      if (data_out !== 12'h411) moved++;
      if (frame_valid) fv_pos = (fv_pos == -1) ? k : 99;
    end
    check("late_fv_edge", fv_pos, 4);
    check("late_data_out_changes", moved, 0);
    check("late_data_out", data_out, 12'h411);
    check("late_err", err_count, 8'd2);
    check("late_regs", regs_out, 32'hC342_A511);
    check("late_state", fsm_state, 2'd0);

    // Reset during CAPTURE of WRITE 12'h4FF
    CS = 1'b0;
    repeat (3) tick();
    data_in = 12'h4FF;
    CS      = 1'b1;
    repeat (3) tick();
    check("abort_in_capture", fsm_state, 2'd1);
    RST = 1'b1;
    #2;
    check("abort_state_in_reset", fsm_state, 2'd0);
    @(negedge CLK);
    RST = 1'b0;
    fv_seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (frame_valid) fv_seen++;
    end
    check("abort_frame_valid", fv_seen, 0);
    check("abort_regs", regs_out, 32'h0000_0000);
    check("abort_data_out", data_out, 12'h000);
    check("abort_err", err_count, 8'd0);
    check("abort_state", fsm_state, 2'd0);

    // Decoding resumes after the abort
    run_frame(12'h4FF, fv_pos);
    check("resume_fv_edge", fv_pos, 4);
    check("resume_regs", regs_out, 32'h0000_00FF);
    check("resume_data_out", data_out, 12'h4FF);

    // Reserved ops saturate the error counter
    for (int i = 0; i < 254; i++) run_frame(12'hC12, fv_pos);
    check("sat_err_254", err_count, 8'hFE);
    run_frame(12'hC12, fv_pos);
    check("sat_err_255", err_count, 8'hFF);
    for (int i = 0; i < 45; i++) run_frame(12'hC12, fv_pos);
    check("sat_err_300", err_count, 8'hFF);
    check("sat_data_out", data_out, 12'hFFF);
    check("sat_regs", regs_out, 32'h0000_00FF);
    check("sat_fv_edge", fv_pos, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
